bist_engine: RTL



---
 rtl/bist_pkg.sv | 45 ++++
 rtl/bist_lfsr.sv | 47 ++++
 rtl/bist_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and polynomial tables for the BIST engine.
// Tap masks select the bits that are XORed into bit 0 of a shift-left
// Fibonacci register. They are maximal-length for every supported width.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } bist_state_e;

  localparam int LFSR_MIN_W = 3;
  localparam int LFSR_MAX_W = 8;
  localparam int MISR_MIN_W = 4;
  localparam int MISR_MAX_W = 8;

  // Pattern-generator taps, indexed by width 3..8.
  function automatic logic [7:0] lfsr_taps(input int width);
    logic [7:0] taps;
    unique case (width)
      3:       taps = 8'h06;  // x^3 + x^2 + 1
      4:       taps = 8'h0C;  // x^4 + x^3 + 1
      5:       taps = 8'h14;  // x^5 + x^3 + 1
      6:       taps = 8'h30;  // x^6 + x^5 + 1
      7:       taps = 8'h60;  // x^7 + x^6 + 1
      default: taps = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
    endcase
    return taps;
  endfunction

  // Signature-register taps, indexed by width 4..8.
  function automatic logic [7:0] misr_taps(input int width);
    logic [7:0] taps;
    unique case (width)
      4:       taps = 8'h0C;  // x^4 + x^3 + 1
      5:       taps = 8'h14;  // x^5 + x^3 + 1
      6:       taps = 8'h30;  // x^6 + x^5 + 1
      7:       taps = 8'h60;  // x^7 + x^6 + 1
      default: taps = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Shift-left Fibonacci LFSR core with synchronous load and step enable.
// par_i is XORed into the next state on every step: tie it to zero for a
// pattern generator, or feed the circuit response to build a MISR.
module bist_lfsr #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             feedback;

  // Next state: load wins over step; otherwise hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    q_d      = q_q;
    feedback = ^(q_q & TAPS);
    if (load_i) begin
      q_d = SEED;
    end else if (en_i) begin
      q_d = {q_q[WIDTH-2:0], feedback} ^ par_i;
    end
  end

  // State register; reset returns to the seed so a bare reset is a valid load.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bist_engine.sv
// Built-in self-test engine: drives LFSR patterns into a combinational CUT,
// compacts its responses in a MISR and compares the signature to GOLDEN.
// Optional feature macro: BIST_ZERO_PATTERN_EN -- when defined, the all-zero
// pattern is applied in the first RUN cycle (LFSR holds its seed meanwhile)
// and counts toward PATTERNS.
module bist_engine
  import bist_pkg::*;
#(
  parameter int               N_IN     = 3,
  parameter int               N_OUT    = 2,
  parameter int               SIG_W    = 4,
  parameter int               PATTERNS = 7,
  parameter logic [SIG_W-1:0] GOLDEN   = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [N_IN-1:0]  CUT_IN,
  input  logic [N_OUT-1:0] CUT_OUT,
  output logic             TEST_MODE,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIG
);

  localparam int               CNT_W     = $clog2(PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PATTERNS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       LFSR_ALL  = lfsr_taps(N_IN);
  localparam logic [7:0]       MISR_ALL  = misr_taps(SIG_W);
  localparam logic [N_IN-1:0]  LFSR_TAP  = LFSR_ALL[N_IN-1:0];
  localparam logic [SIG_W-1:0] MISR_TAP  = MISR_ALL[SIG_W-1:0];
  localparam logic [N_IN-1:0]  LFSR_SEED = N_IN'(1);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             test_mode_q, test_mode_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  logic             run_load;
  logic             lfsr_en;
  logic             misr_en;
  logic             pattern_zero;
  logic [N_IN-1:0]  lfsr_q;
  logic [SIG_W-1:0] misr_q;

`ifdef BIST_ZERO_PATTERN_EN
  // High during the first RUN cycle, when the all-zero pattern is applied.
  logic zero_q, zero_d;
`endif

  // Pattern generator: serial feedback only, no parallel input.
  bist_lfsr #(
    .WIDTH (N_IN),
    .TAPS  (LFSR_TAP),
    .SEED  (LFSR_SEED)
  ) u_pattern_gen (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (run_load),
    .en_i   (lfsr_en),
    .par_i  ('0),
    .q_o    (lfsr_q)
  );

  // Signature register: CUT response folded in, zero-extended to SIG_W.
  bist_lfsr #(
    .WIDTH (SIG_W),
    .TAPS  (MISR_TAP),
    .SEED  ('0)
  ) u_misr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (run_load),
    .en_i   (misr_en),
    .par_i  (SIG_W'(CUT_OUT)),
    .q_o    (misr_q)
  );

`ifdef BIST_ZERO_PATTERN_EN
  assign pattern_zero = zero_q;
`else
  assign pattern_zero = 1'b0;
`endif

  // FSM next-state, run control and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    test_mode_d = 1'b0;
    done_d      = done_q;
    pass_d      = pass_q;
    sig_d       = sig_q;
    run_load    = 1'b0;
    lfsr_en     = 1'b0;
    misr_en     = 1'b0;
`ifdef BIST_ZERO_PATTERN_EN
    zero_d      = zero_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // A restart clears the previous result on the same edge RUN is entered.
        if (START) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          test_mode_d = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          sig_d       = '0;
          run_load    = 1'b1;
`ifdef BIST_ZERO_PATTERN_EN
          zero_d      = 1'b1;
`endif
        end
      end

      ST_RUN: begin
        // One pattern per cycle; the LFSR holds its seed under the zero pattern.
        misr_en = 1'b1;
        lfsr_en = !pattern_zero;
        cnt_d   = cnt_q + CNT_ONE;
`ifdef BIST_ZERO_PATTERN_EN
        zero_d  = 1'b0;
`endif
        if (cnt_d == CNT_LAST) begin
          state_d = ST_CMP;
        end else begin
          test_mode_d = 1'b1;
        end
      end

      ST_CMP: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = (misr_q == GOLDEN);
        sig_d   = misr_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers; reset discards any run in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      test_mode_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      sig_q       <= '0;
`ifdef BIST_ZERO_PATTERN_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      test_mode_q <= test_mode_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      sig_q       <= sig_d;
`ifdef BIST_ZERO_PATTERN_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign CUT_IN    = (state_q == ST_RUN && !pattern_zero) ? lfsr_q : '0;
  assign TEST_MODE = test_mode_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIG       = sig_q;

endmodule
